// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern generator: three debounced buttons pick the pattern mode,
// step rate and freeze; the LED vector advances one pattern step per prescaler period.
module led_pattern_engine #(
    parameter int unsigned NUM_LEDS        = 5,
    parameter int unsigned TICK_DIV        = 3000000,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_mode,
    input  logic                btn_speed,
    input  logic                btn_hold,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode_o,
    output logic [1:0]          rate_o,
    output logic                tick_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]         raw_c;
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         deb_q, deb_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         press_q, press_d;

    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          rate_q, rate_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick_q, tick_d;
    logic [PW-1:0]       last_c;
    logic                ev_mode_c, ev_speed_c, hold_c;

    assign raw_c = {btn_hold, btn_speed, btn_mode};

    function automatic logic [NUM_LEDS-1:0] init_pat(input logic [1:0] m);
        init_pat = '0;
        if (m == 2'd1) begin
            init_pat[0] = 1'b1;
        end else if (m == 2'd3) begin
            for (int unsigned i = 0; i < NUM_LEDS; i += 2) init_pat[i] = 1'b1;
        end
    endfunction

    function automatic logic [NUM_LEDS-1:0] next_pat(input logic [1:0] m,
                                                      input logic [NUM_LEDS-1:0] cur);
        case (m)
            2'd1:    next_pat = {cur[NUM_LEDS-2:0], cur[NUM_LEDS-1]};
            2'd2:    next_pat = cur + NUM_LEDS'(1);
            default: next_pat = ~cur;
        endcase
    endfunction

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        press_d = deb_d[1:0] & ~deb_q[1:0];
    end

    assign ev_mode_c  = press_q[0];
    assign ev_speed_c = press_q[1];
    assign hold_c     = deb_q[2];
    assign last_c     = PW'((TICK_DIV >> rate_q) - 1);

    // Events outrank the step tick; hold freezes stepping but not events.
    always_comb begin
        mode_d = mode_q;
        rate_d = rate_q;
        led_d  = led_q;
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (ev_mode_c || ev_speed_c) begin
            if (ev_mode_c) begin
                mode_d = mode_q + 2'd1;
                led_d  = init_pat(mode_q + 2'd1);
            end
            if (ev_speed_c) rate_d = rate_q + 2'd1;
            pre_d = '0;
        end else if (!hold_c) begin
            if (pre_q == last_c) begin
                pre_d  = '0;
                led_d  = next_pat(mode_q, led_q);
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            press_q <= '0;
            led_q   <= '0;
            mode_q  <= '0;
            rate_q  <= '0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    assign led    = led_q;
    assign mode_o = mode_q;
    assign rate_o = rate_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed vector table, timing corner sequences and
// randomized button activity, all checked every cycle against a behavioural model.
module tb_led_pattern_engine;

    localparam int N   = 5;
    localparam int TD  = 16;
    localparam int DEB = 4;

    logic         clk;
    logic         rst_n;
    logic         btn_mode, btn_speed, btn_hold;
    logic [N-1:0] led;
    logic [1:0]   mode_o, rate_o;
    logic         tick_o;

    int total = 0;
    int bad   = 0;

    led_pattern_engine #(.NUM_LEDS(N), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_speed(btn_speed),
        .btn_hold(btn_hold), .led(led), .mode_o(mode_o), .rate_o(rate_o), .tick_o(tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_led, m_mode, m_rate, m_pre, m_tick;
    int m_sy1 [3];
    int m_sy2 [3];
    int m_deb [3];
    int m_run [3];
    int m_ev  [2];

    typedef struct {
        logic bm, bs, bh;
        int   n;
        int   exp_mode;
        int   exp_rate;
    } vec_t;
    vec_t vecs [21];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int init_model(input int m);
        int v = 0;
        if (m == 1) return 1;
        if (m == 3) begin
            for (int i = 0; i < N; i += 2) v += (1 << i);
        end
        return v;
    endfunction

    function automatic int next_model(input int m, input int v);
        int full = (1 << N);
        if (m == 1) return ((v * 2) % full) + v / (1 << (N - 1));
        if (m == 2) return (v + 1) % full;
        return (full - 1) - v;
    endfunction

    task automatic model_reset();
        m_led = 0; m_mode = 0; m_rate = 0; m_pre = 0; m_tick = 0;
        for (int b = 0; b < 3; b++) begin
            m_sy1[b] = 0; m_sy2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
        end
        m_ev[0] = 0; m_ev[1] = 0;
    endtask

    // One clock edge of the model, using the pre-edge view of events and hold.
    task automatic model_step();
        int raw [3];
        int period;
        raw[0] = int'(btn_mode); raw[1] = int'(btn_speed); raw[2] = int'(btn_hold);
        period = TD / (1 << m_rate);
        m_tick = 0;
        if (m_ev[0] != 0 || m_ev[1] != 0) begin
            if (m_ev[0] != 0) begin
                m_mode = (m_mode + 1) % 4;
                m_led  = init_model(m_mode);
            end
            if (m_ev[1] != 0) m_rate = (m_rate + 1) % 4;
            m_pre = 0;
        end else if (m_deb[2] == 0) begin
            if (m_pre == period - 1) begin
                m_pre  = 0;
                m_led  = next_model(m_mode, m_led);
                m_tick = 1;
            end else begin
                m_pre++;
            end
        end
        for (int b = 0; b < 3; b++) begin
            if (b < 2) m_ev[b] = 0;
            if (m_sy2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = m_sy2[b];
                    m_run[b] = 0;
                    if (b < 2 && m_deb[b] == 1) m_ev[b] = 1;
                end
            end else begin
                m_run[b] = 0;
            end
            m_sy2[b] = m_sy1[b];
            m_sy1[b] = raw[b];
        end
    endtask

    task automatic check_all();
        chk("led",  int'(led),    m_led);
        chk("mode", int'(mode_o), m_mode);
        chk("rate", int'(rate_o), m_rate);
        chk("tick", int'(tick_o), m_tick);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_btn(input logic m, input logic s, input logic h);
        btn_mode = m; btn_speed = s; btn_hold = h;
    endtask

    initial begin
        int guard;
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 40, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 20, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 10, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  3, 1, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0,  3, 1, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0,  3, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0,  3, 1, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 10, 1, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 10, 1, 2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 10, 1, 2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 10, 1, 3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 40, 1, 3};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 10, 1, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 40, 1, 0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 10, 2, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 10, 2, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 100, 2, 0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 60, 2, 0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 10, 3, 1};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 10, 3, 1};

        rst_n = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_led",  int'(led),    0);
        chk("reset_mode", int'(mode_o), 0);
        chk("reset_rate", int'(rate_o), 0);
        chk("reset_tick", int'(tick_o), 0);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 21; v++) begin
            set_btn(vecs[v].bm, vecs[v].bs, vecs[v].bh);
            repeat (vecs[v].n) cycle();
            chk($sformatf("vec%0d_mode", v), int'(mode_o), vecs[v].exp_mode);
            chk($sformatf("vec%0d_rate", v), int'(rate_o), vecs[v].exp_rate);
        end

        // Mode press latency: first change lands on edge 3+DEBOUNCE_CYCLES
        @(negedge clk);
        rst_n = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        btn_mode = 1'b1;
        repeat (6) cycle();
        chk("edge6_mode", int'(mode_o), 0);
        cycle();
        chk("edge7_mode", int'(mode_o), 1);
        chk("edge7_led",  int'(led),    1);
        btn_mode = 1'b0;
        repeat (10) cycle();

        // Mode+speed events landing exactly on prescaler == P-1
        guard = 0;
        while (m_pre != 9 && guard < 40) begin
            cycle();
            guard++;
        end
        chk("align_timeout", int'(guard < 40), 1);
        set_btn(1'b1, 1'b1, 1'b0);
        repeat (6) cycle();
        cycle();
        chk("coincide_tick", int'(tick_o), 0);
        chk("coincide_mode", int'(mode_o), 2);
        chk("coincide_rate", int'(rate_o), 1);
        chk("coincide_led",  int'(led),    0);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (10) cycle();

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led",  int'(led),    0);
        chk("async_mode", int'(mode_o), 0);
        chk("async_rate", int'(rate_o), 0);
        chk("async_tick", int'(tick_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized button activity
        for (int k = 0; k < 150; k++) begin
            set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(1, 12)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
